shifter: RTL and testbench
==========================

// Module: shifter
// PURPOSE
//  16-bit single-step shifter for the Simple RISC Machine datapath (sits between register-file read port B and ALU input B).
//  Combinational result sout is always live (datapath timing relies on it).
//  Also provides a registered copy with a valid flag and a shifted-out carry bit for pipelined/status use.
// PARAMETERS
//  W       16   datapath width; all shift semantics below hold for any W >= 2
// PORTS
//  clk        in   1   rising-edge clock (registered stage only)
//  rst_n      in   1   asynchronous, active-low reset
//  in         in   W   operand
//  shift      in   2   op: 00 pass, 01 LSL#1, 10 LSR#1, 11 ASR#1
//  in_valid   in   1   capture in/shift result into registered stage this cycle
//  sout       out  W   combinational result
//  sout_q     out  W   registered result
//  cout_q     out  1   registered shifted-out bit (0 for op 00)
//  out_valid  out  1   sout_q/cout_q hold a captured result
// BEHAVIOUR
//  - Combinational, zero latency:
//    00: sout = in
//    01: sout = {in[W-2:0],1'b0}; cout = in[W-1]
//    10: sout = {1'b0,in[W-1:1]}; cout = in[0]
//    11: sout = {in[W-1],in[W-1:1]} (MSB replicated); cout = in[0]
//  - No X propagation: every op code is defined; no default/latch path.
//  - Registered stage, posedge clk:
//    in_valid=1: sout_q<=sout, cout_q<=cout, out_valid<=1
//    in_valid=0: sout_q/cout_q hold, out_valid<=0
//    latency: 1 cycle from in_valid to out_valid
//  - rst_n=0 (any time, async): sout_q=0, cout_q=0, out_valid=0.
//    sout is unaffected by reset (pure function of in/shift).
//  - Deassertion: first capture is on the first posedge with rst_n=1 and in_valid=1.
//  - Reset asserted in the same cycle as in_valid: reset wins, nothing captured.
//  - Back-to-back in_valid: captures every cycle, no bubbles.
// CONFIGURATION
//  SHIFTER_FLAGS_EN defined:
//    adds outputs zero_q (sout_q==0) and neg_q (sout_q[W-1]), registered with sout_q, reset to 0.
//  Undefined: those ports and their logic are absent; all other behaviour unchanged.
// STRUCTURE
//  - shifter_pkg: typedef enum logic [1:0] shift_op_t {SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11}; localparam DEFAULT_W=16.
//  - Sub-module shifter_core: combinational (in, shift) -> (sout, cout).
//    Top adds the register stage and optional flags.
// TESTING
//  - in=16'h00F0, shift=00 -> sout=16'h00F0; after capture cout_q=0.
//  - in=16'h00F0, shift=01 -> sout=16'h01E0; shift=10 -> sout=16'h0078.
//  - in=16'h80F0, shift=11 -> sout=16'hC078, cout=0.
//    Same input, shift=10 -> sout=16'h4078.
//  - in=16'h8001: shift=01 -> sout=16'h0002, cout_q=1; shift=10 -> sout=16'h4000, cout_q=1.
//  - in_valid pulse with in=16'h0001, shift=10:
//    next cycle out_valid=1, sout_q=0, cout_q=1 (zero_q=1 if SHIFTER_FLAGS_EN).
//    Following cycle with in_valid=0: out_valid=0.
//  - Assert rst_n=0 mid-stream between clock edges:
//    sout_q=0, cout_q=0, out_valid=0 immediately; sout still tracks in/shift.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and constants for the single-step datapath shifter.
package shifter_pkg;

  localparam int unsigned DEFAULT_W = 16;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational single-step shift: (in, shift) -> (sout, cout), zero latency.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic [W-1:0] in,
  input  logic [1:0]   shift,
  output logic [W-1:0] sout,
  output logic         cout
);

  shift_op_t op;
  assign op = shift_op_t'(shift);

  // All four codes are decoded, so there is no fallback path that could produce X.
  always_comb begin
    sout = in;
    cout = 1'b0;
    unique case (op)
      SH_NONE: begin
        sout = in;
        cout = 1'b0;
      end
      SH_LSL: begin
        sout = {in[W-2:0], 1'b0};
        cout = in[W-1];
      end
      SH_LSR: begin
        sout = {1'b0, in[W-1:1]};
        cout = in[0];
      end
      SH_ASR: begin
        sout = {in[W-1], in[W-1:1]};
        cout = in[0];
      end
    endcase
  end

endmodule

// File: rtl/shifter.sv
// Datapath shifter: live combinational result plus a registered copy with carry and valid.
// Optional SHIFTER_FLAGS_EN adds registered zero_q/neg_q flags of sout_q.
module shifter
  import shifter_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in,
  input  logic [1:0]   shift,
  input  logic         in_valid,
  output logic [W-1:0] sout,
  output logic [W-1:0] sout_q,
  output logic         cout_q,
`ifdef SHIFTER_FLAGS_EN
  output logic         zero_q,
  output logic         neg_q,
`endif
  output logic         out_valid
);

  logic         cout;
  logic [W-1:0] res_d, res_q;
  logic         carry_d, carry_q;
  logic         valid_d, valid_q;

  shifter_core #(
    .W(W)
  ) u_core (
    .in   (in),
    .shift(shift),
    .sout (sout),
    .cout (cout)
  );

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      res_d   = sout;
      carry_d = cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sout_q    = res_q;
  assign cout_q    = carry_q;
  assign out_valid = valid_q;

`ifdef SHIFTER_FLAGS_EN
  logic zero_d, zero_fq;
  logic neg_d, neg_fq;

  // Flags are derived from the value being captured so they stay aligned with sout_q.
  always_comb begin
    zero_d = zero_fq;
    neg_d  = neg_fq;
    if (in_valid) begin
      zero_d = (sout == '0);
      neg_d  = sout[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_fq <= 1'b0;
      neg_fq  <= 1'b0;
    end else begin
      zero_fq <= zero_d;
      neg_fq  <= neg_d;
    end
  end

  assign zero_q = zero_fq;
  assign neg_q  = neg_fq;
`endif

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: arithmetic reference model plus directed literal vectors.
module tb_shifter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in = '0;
  logic [1:0]   shift = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] sout, sout_q;
  logic         cout_q, out_valid;
`ifdef SHIFTER_FLAGS_EN
  logic         zero_q, neg_q;
`endif

  int checks = 0;
  int errors = 0;

  shifter #(
    .W(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .shift    (shift),
    .in_valid (in_valid),
    .sout     (sout),
    .sout_q   (sout_q),
    .cout_q   (cout_q),
`ifdef SHIFTER_FLAGS_EN
    .zero_q   (zero_q),
    .neg_q    (neg_q),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift expressed as integer arithmetic on the unsigned operand.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] a, input logic [1:0] op);
    int v, r, c, half;
    v    = int'(a);
    half = 1 << (W - 1);
    case (op)
      2'd0: begin r = v; c = 0; end
      2'd1: begin r = (v * 2) % (2 * half); c = v / half; end
      2'd2: begin r = v / 2; c = v % 2; end
      default: begin r = v / 2 + ((v >= half) ? half : 0); c = v % 2; end
    endcase
    return {c[0], r[W-1:0]};
  endfunction

  logic [W-1:0] m_sout_q = '0;
  logic         m_cout_q = 1'b0;
  logic         m_valid  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sout_q <= '0;
      m_cout_q <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        {m_cout_q, m_sout_q} <= ref_shift(in, shift);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [W:0] r;
    r = ref_shift(in, shift);
    chk("cyc_sout", 32'(sout), 32'(r[W-1:0]));
    chk("cyc_sout_q", 32'(sout_q), 32'(m_sout_q));
    chk("cyc_cout_q", 32'(cout_q), 32'(m_cout_q));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
`ifdef SHIFTER_FLAGS_EN
    chk("cyc_zero_q", 32'(zero_q), 32'(m_sout_q == '0));
    chk("cyc_neg_q", 32'(neg_q), 32'(m_sout_q[W-1]));
`endif
  end

  typedef struct {
    logic [15:0] a;
    logic [1:0]  op;
    logic [15:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[10] = '{
    '{16'h00F0, 2'b00, 16'h00F0, 1'b0},
    '{16'h00F0, 2'b01, 16'h01E0, 1'b0},
    '{16'h00F0, 2'b10, 16'h0078, 1'b0},
    '{16'h80F0, 2'b11, 16'hC078, 1'b0},
    '{16'h80F0, 2'b10, 16'h4078, 1'b0},
    '{16'h8001, 2'b01, 16'h0002, 1'b1},
    '{16'h8001, 2'b10, 16'h4000, 1'b1},
    '{16'h8001, 2'b11, 16'hC000, 1'b1},
    '{16'h8001, 2'b00, 16'h8001, 1'b0},
    '{16'h0001, 2'b10, 16'h0000, 1'b1}
  };

  initial begin
    logic [W:0] r;
    #2;
    chk("rst_sout_q", 32'(sout_q), 32'h0);
    chk("rst_cout_q", 32'(cout_q), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    in = 16'h00F0;
    shift = 2'b01;
    #1 chk("rst_sout_live", 32'(sout), 32'h01E0);

    // Capture attempted while still in reset: nothing may land.
    in_valid = 1'b1;
    @(posedge clk);
    #1 chk("in_reset_no_capture", 32'(out_valid), 32'h0);
    chk("in_reset_sout_q", 32'(sout_q), 32'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Back-to-back captures of the literal vectors.
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      in = vecs[i].a;
      shift = vecs[i].op;
      in_valid = 1'b1;
      #1;
      chk("lit_sout", 32'(sout), 32'(vecs[i].s));
      r = ref_shift(vecs[i].a, vecs[i].op);
      chk("model_pin", 32'(r), 32'({vecs[i].c, vecs[i].s}));
      @(posedge clk);
      #1;
      chk("lit_sout_q", 32'(sout_q), 32'(vecs[i].s));
      chk("lit_cout_q", 32'(cout_q), 32'(vecs[i].c));
      chk("lit_out_valid", 32'(out_valid), 32'h1);
`ifdef SHIFTER_FLAGS_EN
      chk("lit_zero_q", 32'(zero_q), 32'(vecs[i].s == 16'h0));
      chk("lit_neg_q", 32'(neg_q), 32'(vecs[i].s[15]));
`endif
    end

    // Idle cycle: valid drops, data holds (last vector was 0001 LSR).
    in_valid = 1'b0;
    in = 16'hFFFF;
    shift = 2'b01;
    @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'h0);
    chk("idle_hold_sout_q", 32'(sout_q), 32'h0);
    chk("idle_hold_cout_q", 32'(cout_q), 32'h1);

    // Capture something nonzero, then reset asynchronously between edges.
    in = 16'h1234;
    shift = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1 chk("pre_rst_sout_q", 32'(sout_q), 32'h2468);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sout_q", 32'(sout_q), 32'h0);
    chk("async_rst_cout_q", 32'(cout_q), 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    in = 16'h8002;
    shift = 2'b11;
    #1 chk("rst_sout_tracks", 32'(sout), 32'hC001);
    @(posedge clk);
    #1 chk("rst_wins_valid", 32'(out_valid), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_cap_valid", 32'(out_valid), 32'h1);
    chk("first_cap_sout_q", 32'(sout_q), 32'hC001);
    chk("first_cap_cout_q", 32'(cout_q), 32'h0);
    in_valid = 1'b0;

    // A few pseudo-random cycles checked only by the model.
    for (int i = 0; i < 40; i++) begin
      in = 16'($urandom);
      shift = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
